fetch_queue: RTL and testbench

//  Instruction buffer between fetch and decode1. It captures {pc, instruction} pairs returned
//  by the 1-cycle-latency instruction memory port. It presents them to decode in order and holds

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch-entry packing and decode opcodes.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [3:0] {
    OP_SUB  = 4'h0,
    OP_MOVL = 4'h8,
    OP_MOVH = 4'h9,
    OP_JMP  = 4'hE,
    OP_MEM  = 4'hF
  } opcode_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode1: FIFO of {pc,instr} with an empty-queue bypass,
// branch flush, early fetch_hold for in-flight imem reads, and a sticky overflow flag.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int SKID    = 1,
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     out_from_q,
  output logic                     fetch_hold,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HOLD_CNT = CW'(DEPTH - 1 - SKID);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg;

  logic q_nonempty, q_full, accept, pop, bypass_consumed, push, drop;

  assign q_nonempty      = (count_reg != '0);
  assign q_full          = (count_reg == FULL_CNT);
  assign out_valid       = !rst && !flush && (q_nonempty || in_valid);
  assign accept          = out_valid && out_ready;
  assign pop             = accept && q_nonempty;
  assign bypass_consumed = accept && !q_nonempty;
  assign push            = in_valid && !flush && !bypass_consumed && (!q_full || pop);
  assign drop            = in_valid && !flush && !bypass_consumed && q_full && !pop;

  assign out_from_q = q_nonempty;
  assign out_pc     = q_nonempty ? mem[head_reg][EW-1:INSTR_W] : in_pc;
  assign out_instr  = q_nonempty ? mem[head_reg][INSTR_W-1:0]  : in_instr;

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
  end

  // Looks at count_next so fetch stops while SKID reads are still in flight.
  assign fetch_hold = !rst && (count_next > HOLD_CNT);
  assign count      = count_reg;
  assign overflow   = overflow_reg;

  // Storage carries no reset; only pointers and count define which entries are live.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (tail_reg == AW'(gi)))
          mem[gi] <= {in_pc, in_instr};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (flush) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (pop)  head_reg <= head_reg + 1'b1;
        if (push) tail_reg <= tail_reg + 1'b1;
      end
      count_reg <= count_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int SKID  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic        out_from_q;
  logic        fetch_hold;
  logic [2:0]  count;
  logic        overflow;

  fetch_queue #(.DEPTH(DEPTH), .SKID(SKID), .PC_W(16), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_from_q(out_from_q), .fetch_hold(fetch_hold),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the buffered instructions in age order, plus the sticky drop flag.
  logic [31:0] model_q[$];
  logic        model_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, step the model across posedge.
  task automatic cycle(input logic fl, input logic iv, input logic [15:0] pc,
                       input logic [15:0] ins, input logic rdy, input bit verbose);
    int          sz;
    logic        exp_valid, served;
    logic [31:0] head;
    int          next_sz;
    flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = rdy;
    #1;
    sz        = model_q.size();
    exp_valid = !fl && (sz != 0 || iv);
    head      = (sz != 0) ? model_q[0] : {pc, ins};
    check("count", 32'(count), 32'(sz));
    check("overflow", 32'(overflow), 32'(model_ovf));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_from_q", 32'(out_from_q), 32'(sz != 0));
    if (exp_valid) begin
      check("out_pc", 32'(out_pc), 32'(head[31:16]));
      check("out_instr", 32'(out_instr), 32'(head[15:0]));
    end
    // Work out what the queue should hold after this edge.
    served = exp_valid && rdy;
    if (fl) begin
      next_sz = 0;
    end else begin
      next_sz = sz;
      if (served && sz != 0) next_sz--;
      if (iv && !(served && sz == 0)) begin
        if (next_sz < DEPTH) next_sz++;
      end
    end
    check("fetch_hold", 32'(fetch_hold), 32'(next_sz > DEPTH - 1 - SKID));
    if (verbose)
      $display("cyc fl=%0b iv=%0b pc=%04h rdy=%0b | out_v=%0b out_pc=%04h q=%0b cnt=%0d hold=%0b ovf=%0b",
               fl, iv, pc, rdy, out_valid, out_pc, out_from_q, count, fetch_hold, overflow);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (served && sz != 0) void'(model_q.pop_front());
      if (iv && !(served && sz == 0)) begin
        if (model_q.size() < DEPTH) model_q.push_back({pc, ins});
        else model_ovf = 1'b1;
      end
    end
    #1;
    check("count_after", 32'(count), 32'(model_q.size()));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    model_ovf = 1'b0;
    #2;
    in_valid = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fetch_hold", 32'(fetch_hold), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Bypass on an empty queue.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'(2 * i), 16'h8100 + 16'(i), 1'b1, 1'b1);

    // Decode stalls, fetch delivers three more, then release drains in order.
    for (int i = 0; i < 5; i++) cycle(1'b0, i < 3, 16'(2 * i), 16'h9200 + 16'(i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, i == 3, 16'h0006, 16'h9203, 1'b1, 1'b1);
    check("drained", 32'(count), 32'd0);

    // Full queue: pop and push in the same cycle.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h0010 + 16'(2 * i), 16'hF000 + 16'(i), 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 16'h0018, 16'hF004, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);

    // Flush with two stored entries and a live input, then a fresh bypass.
    cycle(1'b0, 1'b1, 16'h0020, 16'hE001, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 16'h0022, 16'hE002, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 16'h0024, 16'hE003, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0040, 16'h0040, 1'b1, 1'b1);

    // Overrun ignoring fetch_hold: drop sets overflow, which survives a flush.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0050 + 16'(2 * i), 16'h0500 + 16'(i), 1'b0, 1'b1);
    check("overflow_set", 32'(overflow), 32'd1);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Async reset mid-cycle with three stored entries.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0060 + 16'(2 * i), 16'h0600 + 16'(i), 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_fetch_hold", 32'(fetch_hold), 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 16'h0070, 16'h0700, 1'b0, 1'b1);
    check("push_after_rst", 32'(count), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 6, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
